// File: rtl/joy_router.sv
// Joystick routing stage: rotates NUM_JOY HPS joystick words onto active-low core ports,
// with per-output autofire and an idle guard window after any routing change.
module joy_router #(
    parameter int unsigned NUM_JOY = 2,
    parameter int unsigned AF_HALF = 1000000,
    parameter int unsigned GUARD   = 65536,
    // Derived from NUM_JOY; leave at default.
    parameter int unsigned RW      = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [16*NUM_JOY-1:0]  joy_in,
    input  logic [RW-1:0]          route,
    input  logic [NUM_JOY-1:0]     af_en,
    output logic [8*NUM_JOY-1:0]   joy_out,
    output logic                   guard
);

    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int unsigned AW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);
    localparam logic [AW-1:0] AF_LAST    = AW'(AF_HALF - 1);
    localparam logic [RW:0]   NUM_JOY_W  = (RW + 1)'(NUM_JOY);

    typedef enum logic {StIdle, StHold} state_e;

    state_e               r_state;
    state_e               w_state_d;
    logic [GW-1:0]        r_guard_cnt;
    logic [GW-1:0]        w_guard_cnt_d;
    logic [AW-1:0]        r_af_cnt;
    logic                 r_af_phase;
    logic [RW-1:0]        r_route_q;
    logic [RW-1:0]        w_route_v;
    logic                 w_route_chg;
    logic                 w_blank;
    logic [8*NUM_JOY-1:0] r_joy_out;
    logic [8*NUM_JOY-1:0] w_joy_d;
    logic                 w_unused;

    // Out-of-range routes collapse to 0 for both selection and change detection.
    assign w_route_v   = ({1'b0, route} >= NUM_JOY_W) ? '0 : route;
    assign w_route_chg = (w_route_v != r_route_q);
    assign w_unused    = ^joy_in;

    always_comb begin
        w_state_d     = r_state;
        w_guard_cnt_d = r_guard_cnt;
        if (w_route_chg) begin
            w_state_d     = StHold;
            w_guard_cnt_d = GUARD_LOAD;
        end else if (r_state == StHold) begin
            if (r_guard_cnt == '0) begin
                w_state_d = StIdle;
            end else begin
                w_guard_cnt_d = r_guard_cnt - 1'b1;
            end
        end
    end

    // Blank in the change cycle too, so the old routing never leaks past the guard edge.
    assign w_blank = (r_state == StHold) || w_route_chg;

    for (genvar k = 0; k < NUM_JOY; k++) begin : g_out
        logic [RW:0]   w_sum;
        logic [RW-1:0] w_sel;
        logic [5:0]    w_j;
        logic          w_fire;

        assign w_sum = (RW + 1)'(k) + {1'b0, r_route_q};
        assign w_sel = (w_sum >= NUM_JOY_W) ? RW'(w_sum - NUM_JOY_W) : w_sum[RW-1:0];

        always_comb begin
            w_j = '0;
            for (int i = 0; i < NUM_JOY; i++) begin
                if (w_sel == RW'(i)) begin
                    w_j = joy_in[16*i +: 6];
                end
            end
        end

        assign w_fire = w_j[4] | (w_j[5] & af_en[k] & r_af_phase);
        assign w_joy_d[8*k +: 8] = {2'b11, ~w_fire, 1'b1, ~w_j[0], ~w_j[1], ~w_j[2], ~w_j[3]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StHold;
            r_guard_cnt <= GUARD_LOAD;
            r_route_q   <= w_route_v;
        end else begin
            r_state     <= w_state_d;
            r_guard_cnt <= w_guard_cnt_d;
            if (w_route_chg) begin
                r_route_q <= w_route_v;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (r_af_cnt == AF_LAST) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt <= r_af_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_blank) begin
            r_joy_out <= '1;
        end else begin
            r_joy_out <= w_joy_d;
        end
    end

    assign joy_out = r_joy_out;
    assign guard   = (r_state == StHold);

endmodule
